// File: rtl/rom_dl_sequencer.sv
// ROM download sequencer: buffers HPS ioctl bytes, paces DPRAM writes, tags region,
// and holds the core in reset until the image is written and settled.
module rom_dl_sequencer #(
  parameter logic [7:0]  ROM_INDEX  = 8'd0,
  parameter int          FIFO_DEPTH = 4,
  parameter int          WR_GAP     = 2,
  parameter int          RESET_HOLD = 1024,
  parameter logic [24:0] ROM_SIZE   = 25'h34300
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        dl_wr,
  output logic [24:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic [4:0]  dl_region,
  output logic        core_reset,
  output logic        rom_ready,
  output logic        rom_err,
  output logic [15:0] rom_sum
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int GAP_W  = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);

  localparam logic [24:0] BOUNDS [18] = '{
    25'h04000, 25'h08000, 25'h0C000, 25'h0E000, 25'h10000, 25'h12000,
    25'h14000, 25'h18000, 25'h1C000, 25'h20000, 25'h24000, 25'h28000,
    25'h2C000, 25'h30000, 25'h34000, 25'h34100, 25'h34200, 25'h34300
  };

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_HOLD, S_RUN} state_t;

  // Region = index of the first boundary strictly above the address.
  function automatic logic [4:0] region_of(input logic [24:0] a);
    logic [4:0] r;
    r = 5'd18;
    for (int i = 17; i >= 0; i--) begin
      if (a < BOUNDS[i]) r = 5'(i);
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic                dl_prev_q;
  logic [32:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                wr_q, wr_d;
  logic [24:0]         addr_q, addr_d, max_q, max_d;
  logic [7:0]          data_q, data_d;
  logic [4:0]          region_q, region_d;
  logic [15:0]         sum_q, sum_d;
  logic                err_q, err_d, any_q, any_d, wait_q, wait_d;

  logic        start_w, push_req_w, full_w, pop_w, push_w, ovf_w, short_w;
  logic [32:0] head_w;

  assign start_w    = ioctl_download && !dl_prev_q && (ioctl_index == ROM_INDEX);
  assign push_req_w = (state_q == S_LOAD) && ioctl_wr && (ioctl_index == ROM_INDEX);
  assign full_w     = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign pop_w      = (cnt_q != '0) && (gap_q == '0);
  // A pop on a full FIFO frees the slot in the same cycle.
  assign push_w     = push_req_w && (!full_w || pop_w);
  assign ovf_w      = push_req_w && full_w && !pop_w;
  assign head_w     = mem_q[rptr_q];
  assign short_w    = !any_q || (({1'b0, max_q} + 26'd1) < {1'b0, ROM_SIZE});

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_w) state_d = S_LOAD;
      S_LOAD:  if (!ioctl_download) state_d = S_DRAIN;
      S_DRAIN: if (cnt_q == '0 && gap_q == '0 && !wr_q) state_d = S_HOLD;
      S_HOLD:  if (hold_q == '0) state_d = S_RUN;
      S_RUN:   if (start_w) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : fsm_out
    core_reset = (state_q != S_RUN);
    rom_ready  = (state_q == S_RUN);
  end

  always_comb begin : ctrl_next
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    hold_d   = hold_q;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    region_d = region_q;
    sum_d    = sum_q;
    err_d    = err_q;
    max_d    = max_q;
    any_d    = any_q;
    if (push_w) begin
      wptr_d = wptr_q + PTR_W'(1);
      any_d  = 1'b1;
      if (ioctl_addr > max_q) max_d = ioctl_addr;
    end
    // The hold counter retriggers on every write so the settle time runs from the last one.
    if (pop_w) begin
      rptr_d   = rptr_q + PTR_W'(1);
      wr_d     = 1'b1;
      addr_d   = head_w[32:8];
      data_d   = head_w[7:0];
      region_d = region_of(head_w[32:8]);
      gap_d    = GAP_W'(WR_GAP - 1);
      hold_d   = HOLD_W'(RESET_HOLD - 1);
      sum_d    = sum_q + {8'd0, head_w[7:0]};
    end else begin
      if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
      if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
    end
    case ({push_w, pop_w})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (ovf_w) err_d = 1'b1;
    if (state_q == S_DRAIN && state_d == S_HOLD && short_w) err_d = 1'b1;
    if (state_q != S_LOAD && state_d == S_LOAD) begin
      sum_d  = '0;
      err_d  = 1'b0;
      max_d  = '0;
      any_d  = 1'b0;
      hold_d = HOLD_W'(RESET_HOLD - 1);
    end
    wait_d = (cnt_d >= CNT_W'(FIFO_DEPTH - 1));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      dl_prev_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      hold_q    <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      region_q  <= '0;
      sum_q     <= '0;
      err_q     <= 1'b0;
      max_q     <= '0;
      any_q     <= 1'b0;
      wait_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dl_prev_q <= ioctl_download;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      hold_q    <= hold_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      region_q  <= region_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
      max_q     <= max_d;
      any_q     <= any_d;
      wait_q    <= wait_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_w) mem_q[wptr_q] <= {ioctl_addr, ioctl_dout};
  end

  assign ioctl_wait = wait_q;
  assign dl_wr      = wr_q;
  assign dl_addr    = addr_q;
  assign dl_data    = data_q;
  assign dl_region  = region_q;
  assign rom_err    = err_q;
  assign rom_sum    = sum_q;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Scoreboard bench for rom_dl_sequencer: randomized ioctl downloads against a queue-based model.
module tb_rom_dl_sequencer;

  localparam logic [7:0]  IDX        = 8'd0;
  localparam int          WR_GAP     = 2;
  localparam int          RESET_HOLD = 64;
  localparam logic [24:0] ROM_SIZE   = 25'h34300;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait, dl_wr, core_reset, rom_ready, rom_err;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic [4:0]  dl_region;
  logic [15:0] rom_sum;

  rom_dl_sequencer #(
    .ROM_INDEX(IDX), .FIFO_DEPTH(4), .WR_GAP(WR_GAP),
    .RESET_HOLD(RESET_HOLD), .ROM_SIZE(ROM_SIZE)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .dl_wr(dl_wr), .dl_addr(dl_addr),
    .dl_data(dl_data), .dl_region(dl_region), .core_reset(core_reset),
    .rom_ready(rom_ready), .rom_err(rom_err), .rom_sum(rom_sum)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [24:0] a;
    logic [7:0]  d;
    logic [4:0]  r;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   BND [18] = '{'h04000, 'h08000, 'h0C000, 'h0E000, 'h10000, 'h12000,
                     'h14000, 'h18000, 'h1C000, 'h20000, 'h24000, 'h28000,
                     'h2C000, 'h30000, 'h34000, 'h34100, 'h34200, 'h34300};

  int checks = 0, failures = 0;
  int cyc = 0, n_wr = 0, last_wr_cyc = -100;
  int model_sum = 0, phase_sent = 0, first_wait_at = -1, wr0 = 0;
  bit sb_on = 1'b1;

  always @(posedge CLK) cyc <= cyc + 1;

  // Region = how many boundaries lie at or below the address.
  function automatic logic [4:0] region_model(input logic [24:0] a);
    int n = 0;
    foreach (BND[i]) if (int'(a) >= BND[i]) n++;
    return 5'(n);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET_N && dl_wr) begin
      n_wr++;
      chk("wr_gap", 32'(cyc - last_wr_cyc >= WR_GAP), 1);
      last_wr_cyc = cyc;
      if (sb_on) begin
        chk("sb_pending", 32'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("dl_addr", 32'(dl_addr), 32'(e.a));
          chk("dl_data", 32'(dl_data), 32'(e.d));
          chk("dl_region", 32'(dl_region), 32'(e.r));
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    model_sum = 0;
    phase_sent = 0;
    first_wait_at = -1;
    wr0 = n_wr;
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_dl();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d, input bit honour, input int idle);
    int g = 0;
    if (honour) begin
      if (ioctl_wait && first_wait_at < 0) first_wait_at = phase_sent;
      while (ioctl_wait && g < 200) begin tick(); g++; end
      if (g >= 200) begin
        checks++; failures++;
        $display("FAIL wait_stuck: ioctl_wait high for %0d cycles, required release", g);
      end
    end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    if (sb_on && ioctl_index == IDX) begin
      expq.push_back('{a: a, d: d, r: region_model(a)});
      model_sum = model_sum + int'(d);
    end
    phase_sent++;
    tick();
    ioctl_wr = 1'b0;
    repeat (idle) tick();
  endtask

  task automatic wait_ready(output int at);
    int g = 0;
    while (!rom_ready && g < 4000) begin tick(); g++; end
    chk("ready_rise", 32'(rom_ready), 1);
    at = cyc;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [24:0] a;
  int at;
  int n_hold;
  logic [24:0] reg_addr [6] = '{25'h03FFF, 25'h04000, 25'h13FFF, 25'h34000, 25'h342FF, 25'h34300};
  logic [4:0]  reg_exp  [6] = '{5'd0, 5'd1, 5'd6, 5'd15, 5'd17, 5'd18};

  initial begin
    // Reset values
    #2 RESET_N = 1'b0;
    tick(); tick();
    chk("rst_core_reset", 32'(core_reset), 1);
    chk("rst_rom_ready", 32'(rom_ready), 0);
    chk("rst_dl_wr", 32'(dl_wr), 0);
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_sum", 32'(rom_sum), 0);
    chk("rst_err", 32'(rom_err), 0);
    chk("rst_addr", 32'(dl_addr), 0);
    RESET_N = 1'b1;
    tick(); tick();

    // Full sparse image to 0x342FF, one strobe every 4 cycles
    start_dl(IDX);
    a = '0;
    forever begin
      send(a, 8'($urandom), 1'b1, 3);
      if (a == 25'h342FF) break;
      a = a + 25'($urandom_range(1, 'h400));
      if (a > 25'h342FF) a = 25'h342FF;
    end
    end_dl();
    wait_ready(at);
    chk("t1_ready_delay", 32'(at - last_wr_cyc), RESET_HOLD);
    chk("t1_count", 32'(n_wr - wr0), 32'(phase_sent));
    chk("t1_sum", 32'(rom_sum), 32'(model_sum & 'hFFFF));
    chk("t1_err", 32'(rom_err), 0);
    chk("t1_core_reset", 32'(core_reset), 0);
    chk("t1_sb_drained", 32'(expq.size()), 0);

    // Non-matching download while running is ignored
    wr0 = n_wr;
    start_dl(8'd1);
    for (int i = 0; i < 3; i++) send(25'(i), 8'($urandom), 1'b0, 1);
    end_dl();
    repeat (5) tick();
    chk("t5_no_wr", 32'(n_wr - wr0), 0);
    chk("t5_ready_kept", 32'(rom_ready), 1);
    chk("t5_core_run", 32'(core_reset), 0);

    // Matching restart, then single writes for region decode and latency
    model_sum = 0;
    wr0 = n_wr;
    ioctl_index = IDX;
    ioctl_download = 1'b1;
    tick();
    chk("t5_core_reset_on_start", 32'(core_reset), 1);
    chk("t5_sum_cleared", 32'(rom_sum), 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      repeat (4) tick();
      ioctl_addr = reg_addr[i];
      ioctl_dout = 8'($urandom);
      ioctl_wr = 1'b1;
      expq.push_back('{a: reg_addr[i], d: ioctl_dout, r: region_model(reg_addr[i])});
      model_sum = model_sum + int'(ioctl_dout);
      tick();
      ioctl_wr = 1'b0;
      tick();
      chk("t4_latency", 32'(dl_wr), 1);
      chk("t4_region_tbl", 32'(dl_region), 32'(reg_exp[i]));
    end
    end_dl();
    wait_ready(at);
    chk("t4_err", 32'(rom_err), 0);
    chk("t4_sum", 32'(rom_sum), 32'(model_sum & 'hFFFF));

    // Back-to-back strobes honouring ioctl_wait
    start_dl(IDX);
    for (int i = 0; i < 24; i++)
      send((i == 0) ? 25'h342FF : 25'(i * 16), 8'($urandom), 1'b1, 0);
    end_dl();
    wait_ready(at);
    chk("t2_wait_first", 32'(first_wait_at), 5);
    chk("t2_count", 32'(n_wr - wr0), 24);
    chk("t2_err", 32'(rom_err), 0);
    chk("t2_sum", 32'(rom_sum), 32'(model_sum & 'hFFFF));

    // Back-to-back strobes ignoring ioctl_wait overflow the FIFO
    sb_on = 1'b0;
    start_dl(IDX);
    for (int i = 0; i < 20; i++)
      send((i == 0) ? 25'h342FF : 25'(i * 16), 8'($urandom), 1'b0, 0);
    end_dl();
    wait_ready(at);
    chk("t2_ovf_err", 32'(rom_err), 1);
    chk("t2_ovf_dropped", 32'((n_wr - wr0) < 20), 1);
    sb_on = 1'b1;

    // Asynchronous reset mid-load with 3 entries queued
    start_dl(IDX);
    for (int i = 0; i < 5; i++) send(25'h342FF - 25'(i), 8'($urandom), 1'b0, 0);
    chk("t6_wait_at3", 32'(ioctl_wait), 1);
    #3 RESET_N = 1'b0;
    #1;
    chk("t6_dl_wr", 32'(dl_wr), 0);
    chk("t6_addr", 32'(dl_addr), 0);
    chk("t6_data", 32'(dl_data), 0);
    chk("t6_region", 32'(dl_region), 0);
    chk("t6_core_reset", 32'(core_reset), 1);
    chk("t6_wait", 32'(ioctl_wait), 0);
    chk("t6_sum", 32'(rom_sum), 0);
    expq.delete();
    ioctl_download = 1'b0;
    tick(); tick();
    RESET_N = 1'b1;
    n_hold = n_wr;
    repeat (20) tick();
    chk("t6_no_wr", 32'(n_wr - n_hold), 0);
    chk("t6_idle_core", 32'(core_reset), 1);
    chk("t6_idle_ready", 32'(rom_ready), 0);

    // Image one byte short
    start_dl(IDX);
    send(25'h00100, 8'($urandom), 1'b1, 3);
    send(25'h02000, 8'($urandom), 1'b1, 3);
    send(25'h34000, 8'($urandom), 1'b1, 3);
    send(25'h342FE, 8'($urandom), 1'b1, 3);
    end_dl();
    repeat (20) tick();
    chk("t3_err_hold", 32'(rom_err), 1);
    chk("t3_core_hold", 32'(core_reset), 1);
    chk("t3_not_ready", 32'(rom_ready), 0);
    wait_ready(at);
    chk("t3_err_run", 32'(rom_err), 1);
    chk("t3_sum", 32'(rom_sum), 32'(model_sum & 'hFFFF));
    chk("t3_sb_drained", 32'(expq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_dl_sequencer.md
Name: rom_dl_sequencer

Overview:
Single-clock controller between the HPS ioctl download stream and the per-ROM DPRAM write ports of the ROM loader.
- Buffers incoming bytes in a small FIFO and paces writes to the DPRAMs.
- Tags each write with a region index that drives chip-select fan-out.
- Holds the core in reset until the ROM image is fully written and settled.
- Reports a 16-bit byte checksum and an error flag for short or overflowed loads.

Parameters:
ROM_INDEX, 8'd0, ioctl_index value identifying the ROM image; all other indices are ignored.
FIFO_DEPTH, 4, FIFO entries; power of 2, minimum 4.
WR_GAP, 2, minimum cycles between dl_wr pulses; minimum 1.
RESET_HOLD, 1024, cycles core_reset stays high after the last DPRAM write.
ROM_SIZE, 25'h34300, expected image length in bytes.

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET_N  in  1  asynchronous active-low reset
ioctl_download  in  1  download in progress
ioctl_index  in  8  image index
ioctl_wr  in  1  one-cycle byte strobe
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
ioctl_wait  out  1  back-pressure to HPS
dl_wr  out  1  one-cycle DPRAM write strobe
dl_addr  out  25  write address
dl_data  out  8  write data
dl_region  out  5  region index 0..18
core_reset  out  1  hold CPUs and video in reset
rom_ready  out  1  image loaded and reset released
rom_err  out  1  sticky: short image or FIFO overflow
rom_sum  out  16  sum of written bytes, mod 2^16

Behaviour:
- Clock and reset: one clock CLK. Reset RESET_N is asynchronous and active-low.
- Reset values: state IDLE, FIFO empty, gap counter 0. Outputs: ioctl_wait=0, dl_wr=0, dl_addr=0, dl_data=0, dl_region=0, core_reset=1, rom_ready=0, rom_err=0, rom_sum=0.
- Reset mid-operation: aborts immediately. FIFO contents are discarded, and no dl_wr is issued afterwards.
- Download start detection: registered rising edge of ioctl_download while ioctl_index==ROM_INDEX.
- State IDLE: core_reset=1. Start detected -> LOAD.
- State LOAD:
  - Entry clears rom_sum, rom_err, max_addr, any_wr. From the cycle after entry: core_reset=1, rom_ready=0.
  - Push {ioctl_addr, ioctl_dout} when ioctl_wr and ioctl_index==ROM_INDEX.
  - A push when the FIFO is full drops the byte and sets rom_err.
  - Each accepted push updates max_addr = max(max_addr, ioctl_addr) and sets any_wr.
  - ioctl_download low -> DRAIN. A write in the same cycle as the download falling edge is still accepted.
- State DRAIN: when the FIFO is empty, the gap counter is 0 and dl_wr=0 -> HOLD. On the transition, set rom_err if !any_wr or max_addr+1 < ROM_SIZE.
- State HOLD: counts RESET_HOLD cycles with core_reset=1, then -> RUN.
- State RUN: core_reset=0, rom_ready=1. A new matching start -> LOAD. A start with a non-matching index is ignored in every state.
- ioctl_wait: registered, equal to (fifo_count >= FIFO_DEPTH-1). This gives one cycle of slack for an in-flight strobe.
- Drain (active in any state):
  - Pop when the FIFO is non-empty and the gap counter is 0.
  - Next cycle: dl_wr=1 with dl_addr, dl_data, dl_region registered from the popped entry, and the gap counter loads WR_GAP-1. The counter decrements to 0.
  - rom_sum += dl_data on each dl_wr (16-bit wrap).
  - dl_addr and dl_data hold their last value while dl_wr=0.
- Latency: push at cycle N into an empty FIFO with gap 0 -> dl_wr at N+1.
- Simultaneous push and pop: both occur, and the count is unchanged. A pop when full frees a slot the same cycle, so a push then is not an overflow.
- dl_region is the index of the first boundary strictly greater than addr in: 04000, 08000, 0C000, 0E000, 10000, 12000, 14000, 18000, 1C000, 20000, 24000, 28000, 2C000, 30000, 34000, 34100, 34200, 34300. If addr is past all boundaries, dl_region=18.

Test Plan:
1. Reset, then a matching download of 0x34300 bytes with one strobe every 4 cycles, WR_GAP=2 -> 0x34300 dl_wr pulses in address order. rom_sum equals the model sum, rom_err=0, rom_ready=1 exactly RESET_HOLD cycles after the last dl_wr.
2. Back-to-back strobes every cycle, WR_GAP=2 -> ioctl_wait asserts at count 3. An HPS model honouring wait loses no bytes and rom_err=0. A model ignoring wait gets rom_err=1 and fewer than the sent number of dl_wr pulses.
3. Image ending at address 0x342FE (one byte short) -> rom_err=1 on entering HOLD; rom_ready still rises after the hold.
4. Region decode: single writes at 0x03FFF, 0x04000, 0x13FFF, 0x34000, 0x342FF, 0x34300 -> dl_region 0, 1, 6, 15, 17, 18 respectively.
5. Download with ioctl_index=1 while in RUN -> no dl_wr, rom_ready stays 1, core_reset stays 0. A following matching download -> core_reset=1 one cycle after the start edge, and rom_sum restarts from 0.
6. RESET_N pulsed low mid-LOAD with 3 entries queued -> outputs return to their reset values asynchronously. No dl_wr after release; state IDLE until the next matching start.
